// File: rtl/usbf_txn_ctrl_if.sv
// Signal bundle between the SIE receive path, endpoint buffers, the TX engine and the
// transaction sequencer. master = SIE/buffer side, slave = usbf_txn_ctrl.
interface usbf_txn_ctrl_if #(
    parameter int EP_NUM = 4
);
    logic              enable_i;
    logic [7:0]        pid_i;
    logic              token_valid_i;
    logic [3:0]        token_ep_i;
    logic              data_valid_i;
    logic              data_complete_i;
    logic              data_crc_err_i;
    logic              handshake_valid_i;
    logic [EP_NUM-1:0] ep_stall_i;
    logic [EP_NUM-1:0] ep_rx_ready_i;
    logic [EP_NUM-1:0] ep_tx_ready_i;
    logic              tx_ready_i;
    logic              tx_valid_o;
    logic [7:0]        tx_pid_o;
    logic [3:0]        ep_o;
    logic              rx_commit_o;
    logic              rx_setup_o;
    logic              rx_discard_o;
    logic              tx_ack_o;
    logic [EP_NUM-1:0] rx_toggle_o;
    logic [EP_NUM-1:0] tx_toggle_o;

    modport master (
        output enable_i, pid_i, token_valid_i, token_ep_i, data_valid_i, data_complete_i,
               data_crc_err_i, handshake_valid_i, ep_stall_i, ep_rx_ready_i, ep_tx_ready_i,
               tx_ready_i,
        input  tx_valid_o, tx_pid_o, ep_o, rx_commit_o, rx_setup_o, rx_discard_o, tx_ack_o,
               rx_toggle_o, tx_toggle_o
    );

    modport slave (
        input  enable_i, pid_i, token_valid_i, token_ep_i, data_valid_i, data_complete_i,
               data_crc_err_i, handshake_valid_i, ep_stall_i, ep_rx_ready_i, ep_tx_ready_i,
               tx_ready_i,
        output tx_valid_o, tx_pid_o, ep_o, rx_commit_o, rx_setup_o, rx_discard_o, tx_ack_o,
               rx_toggle_o, tx_toggle_o
    );
endinterface

// File: rtl/usbf_txn_ctrl.sv
// USB device transaction sequencer: decodes tokens, picks the handshake/data response,
// tracks per-endpoint data toggles and drives endpoint buffer commit/discard/release.
module usbf_txn_ctrl #(
    parameter int EP_NUM  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    usbf_txn_ctrl_if.slave bus
);
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_PING  = 8'hB4;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_RX_DATA, S_TX_HS, S_TX_DATA, S_WAIT_ACK} state_t;

    state_t            state_q, state_d, dec_state;
    logic [7:0]        tok_pid_q, tok_pid_d;
    logic [3:0]        ep_q, ep_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              frozen_q, frozen_d;
    logic              tx_valid_q, tx_valid_d, dec_tx_valid;
    logic [7:0]        tx_pid_q, tx_pid_d, dec_tx_pid;
    logic              rx_commit_q, rx_commit_d, rx_setup_q, rx_setup_d;
    logic              rx_discard_q, rx_discard_d, tx_ack_q, tx_ack_d;
    logic [EP_NUM-1:0] rx_tog_q, rx_tog_d, tx_tog_q, tx_tog_d;
    logic              dec_setup, tok_hit, take_token, data_pid_ok;
    logic [15:0]       stall_w, rx_rdy_w, tx_rdy_w, rx_t, tx_t;

    // Per-endpoint vectors widened to 16 so the 4-bit endpoint number indexes them directly.
    assign stall_w  = 16'(bus.ep_stall_i);
    assign rx_rdy_w = 16'(bus.ep_rx_ready_i);
    assign tx_rdy_w = 16'(bus.ep_tx_ready_i);
    assign tok_hit  = bus.token_valid_i && (32'(bus.token_ep_i) < EP_NUM);
    assign data_pid_ok = (bus.pid_i == PID_DATA0) || (bus.pid_i == PID_DATA1);

    // Response to a fresh token, shared by IDLE and the RX_DATA preemption path.
    always_comb begin
        dec_state    = S_IDLE;
        dec_tx_valid = 1'b0;
        dec_tx_pid   = tx_pid_q;
        dec_setup    = 1'b0;
        case (bus.pid_i)
            PID_SETUP: begin
                dec_state = S_RX_DATA;
                dec_setup = 1'b1;
            end
            PID_OUT: dec_state = S_RX_DATA;
            PID_PING: begin
                dec_state    = S_TX_HS;
                dec_tx_valid = 1'b1;
                dec_tx_pid   = stall_w[bus.token_ep_i] ? PID_STALL :
                               rx_rdy_w[bus.token_ep_i] ? PID_ACK : PID_NAK;
            end
            PID_IN: begin
                dec_tx_valid = 1'b1;
                if (stall_w[bus.token_ep_i] || !tx_rdy_w[bus.token_ep_i]) begin
                    dec_state  = S_TX_HS;
                    dec_tx_pid = stall_w[bus.token_ep_i] ? PID_STALL : PID_NAK;
                end else begin
                    dec_state  = S_TX_DATA;
                    dec_tx_pid = tx_t[bus.token_ep_i] ? PID_DATA1 : PID_DATA0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tok_pid_d    = tok_pid_q;
        ep_d         = ep_q;
        cnt_d        = cnt_q;
        frozen_d     = frozen_q;
        tx_valid_d   = tx_valid_q;
        tx_pid_d     = tx_pid_q;
        rx_commit_d  = 1'b0;
        rx_setup_d   = 1'b0;
        rx_discard_d = 1'b0;
        tx_ack_d     = 1'b0;
        rx_t         = 16'(rx_tog_q);
        tx_t         = 16'(tx_tog_q);
        take_token   = 1'b0;

        case (state_q)
            S_IDLE: take_token = tok_hit;
            S_RX_DATA: begin
                if (bus.data_complete_i) begin
                    state_d = S_IDLE;
                    if (bus.data_crc_err_i || !data_pid_ok) begin
                        rx_discard_d = 1'b1;
                    end else begin
                        state_d    = S_TX_HS;
                        tx_valid_d = 1'b1;
                        tx_pid_d   = PID_ACK;
                        if (tok_pid_q == PID_SETUP) begin
                            rx_commit_d = 1'b1;
                            rx_setup_d  = 1'b1;
                            rx_t[ep_q]  = 1'b1;
                        end else if (stall_w[ep_q]) begin
                            tx_pid_d     = PID_STALL;
                            rx_discard_d = 1'b1;
                        end else if (!rx_rdy_w[ep_q]) begin
                            tx_pid_d     = PID_NAK;
                            rx_discard_d = 1'b1;
                        end else if ((bus.pid_i == PID_DATA1) != rx_t[ep_q]) begin
                            rx_discard_d = 1'b1;  // duplicate: host missed our ACK
                        end else begin
                            rx_commit_d = 1'b1;
                            rx_t[ep_q]  = ~rx_t[ep_q];
                        end
                    end
                end else if (tok_hit && !frozen_q) begin
                    rx_discard_d = 1'b1;
                    take_token   = 1'b1;
                end else if (bus.data_valid_i || frozen_q) begin
                    frozen_d = 1'b1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rx_discard_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_TX_HS: begin
                if (bus.tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_TX_DATA: begin
                if (bus.tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_WAIT_ACK;
                    cnt_d      = 10'd0;
                end
            end
            S_WAIT_ACK: begin
                if (bus.handshake_valid_i) begin
                    state_d = S_IDLE;
                    if (bus.pid_i == PID_ACK) begin
                        tx_ack_d   = 1'b1;
                        tx_t[ep_q] = ~tx_t[ep_q];
                    end
                end else if (bus.token_valid_i || cnt_q == TIMEOUT_CNT) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_token) begin
            tok_pid_d  = bus.pid_i;
            ep_d       = bus.token_ep_i;
            state_d    = dec_state;
            tx_valid_d = dec_tx_valid;
            tx_pid_d   = dec_tx_pid;
            cnt_d      = 10'd0;
            frozen_d   = 1'b0;
            if (dec_setup) begin
                rx_t[bus.token_ep_i] = 1'b0;
                tx_t[bus.token_ep_i] = 1'b1;
            end
        end

        rx_tog_d = rx_t[EP_NUM-1:0];
        tx_tog_d = tx_t[EP_NUM-1:0];

        if (!bus.enable_i) begin
            state_d      = S_IDLE;
            cnt_d        = 10'd0;
            frozen_d     = 1'b0;
            tx_valid_d   = 1'b0;
            rx_commit_d  = 1'b0;
            rx_setup_d   = 1'b0;
            rx_discard_d = 1'b0;
            tx_ack_d     = 1'b0;
            rx_tog_d     = '0;
            tx_tog_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            tok_pid_q    <= 8'h00;
            ep_q         <= 4'd0;
            cnt_q        <= 10'd0;
            frozen_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_pid_q     <= 8'h00;
            rx_commit_q  <= 1'b0;
            rx_setup_q   <= 1'b0;
            rx_discard_q <= 1'b0;
            tx_ack_q     <= 1'b0;
            rx_tog_q     <= '0;
            tx_tog_q     <= '0;
        end else begin
            state_q      <= state_d;
            tok_pid_q    <= tok_pid_d;
            ep_q         <= ep_d;
            cnt_q        <= cnt_d;
            frozen_q     <= frozen_d;
            tx_valid_q   <= tx_valid_d;
            tx_pid_q     <= tx_pid_d;
            rx_commit_q  <= rx_commit_d;
            rx_setup_q   <= rx_setup_d;
            rx_discard_q <= rx_discard_d;
            tx_ack_q     <= tx_ack_d;
            rx_tog_q     <= rx_tog_d;
            tx_tog_q     <= tx_tog_d;
        end
    end

    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.tx_pid_o     = tx_pid_q;
    assign bus.ep_o         = ep_q;
    assign bus.rx_commit_o  = rx_commit_q;
    assign bus.rx_setup_o   = rx_setup_q;
    assign bus.rx_discard_o = rx_discard_q;
    assign bus.tx_ack_o     = tx_ack_q;
    assign bus.rx_toggle_o  = rx_tog_q;
    assign bus.tx_toggle_o  = tx_tog_q;
endmodule

// File: doc/usbf_txn_ctrl.md
# usbf_txn_ctrl

USB device transaction sequencer that sits between the SIE receive path (`usbf_sie_rx`) and the SIE transmit engine. It consumes decoded token, data and handshake events. For each transaction it decides the response: ACK, NAK, STALL, DATA0/DATA1 or silence. It tracks per-endpoint data toggles and tells endpoint buffers when to commit, discard or release packets, with bus turnaround timeouts.

## Interface
- `EP_NUM`, default 4: number of endpoints, range 1..16. Tokens with `ep >= EP_NUM` are ignored.
- `TIMEOUT`, default 255: turnaround timeout in clk_i cycles, range 1..1023. The counter is 10 bits.
- Reset is `rst_i`, asynchronous, active-high. The clock is `clk_i`.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `enable_i` in 1: low forces IDLE and clears toggles, counter and pulses.
- `pid_i` in 8: most recent PID from RX.
- `token_valid_i` in 1: pulse, address-matched token.
- `token_ep_i` in 4: token endpoint.
- `data_valid_i` in 1: RX data-phase activity. Any pulse stops the RX_DATA timer.
- `data_complete_i` in 1: pulse, data packet ended.
- `data_crc_err_i` in 1: CRC16 error, valid with `data_complete_i`.
- `handshake_valid_i` in 1: pulse, handshake received. `pid_i` holds the handshake PID.
- `ep_stall_i` in EP_NUM: per-endpoint halt.
- `ep_rx_ready_i` in EP_NUM: OUT buffer has room for a max-size packet.
- `ep_tx_ready_i` in EP_NUM: IN buffer holds a packet.
- `tx_valid_o` out 1: request to transmit a packet.
- `tx_pid_o` out 8: PID to send.
- `tx_ready_i` in 1: TX engine finished the packet. Transfer happens when `tx_valid_o & tx_ready_i`.
- `ep_o` out 4: latched endpoint of the current transaction.
- `rx_commit_o` out 1: pulse, keep the received packet.
- `rx_setup_o` out 1: pulse, together with `rx_commit_o` for SETUP.
- `rx_discard_o` out 1: pulse, drop the received packet.
- `tx_ack_o` out 1: pulse, IN packet acknowledged, release the buffer.
- `rx_toggle_o` out EP_NUM: expected OUT toggle.
- `tx_toggle_o` out EP_NUM: next IN toggle.

## Operation
- PIDs:
  - OUT E1, IN 69, SETUP 2D, PING B4.
  - DATA0 C3, DATA1 4B.
  - ACK D2, NAK 5A, STALL 1E.
- States:
  - IDLE → RX_DATA | TX_HS | TX_DATA.
  - RX_DATA → TX_HS | IDLE.
  - TX_HS → IDLE.
  - TX_DATA → WAIT_ACK.
  - WAIT_ACK → IDLE.
- IDLE, on `token_valid_i` with `ep < EP_NUM`: latch ep and token PID, then decode the token.
  - SETUP: `rx_toggle[ep]=0`, `tx_toggle[ep]=1`, go to RX_DATA. SETUP ignores stall.
  - OUT: go to RX_DATA.
  - PING: go to TX_HS. Response is STALL if stalled, else ACK if `ep_rx_ready_i[ep]`, else NAK.
  - IN: STALL (TX_HS) if stalled, else NAK (TX_HS) if `!ep_tx_ready_i[ep]`. Otherwise go to TX_DATA with DATA0/DATA1 chosen by `tx_toggle[ep]`.
  - Any other PID: stay in IDLE.
- RX_DATA, on `data_complete_i`:
  - CRC error, or `pid_i` not DATA0/DATA1: `rx_discard_o`, go to IDLE with no handshake.
  - SETUP: ACK, `rx_commit_o` plus `rx_setup_o`, `rx_toggle[ep]=1`.
  - OUT, stalled: STALL and discard.
  - OUT, not `ep_rx_ready_i[ep]`: NAK and discard.
  - OUT, data toggle ≠ `rx_toggle[ep]`: ACK and discard (duplicate packet).
  - OUT, otherwise: ACK, commit, flip `rx_toggle[ep]`.
- RX_DATA, timeout or a new `token_valid_i` before the data phase: `rx_discard_o`. A new token is then decoded as in IDLE in the same cycle.
- WAIT_ACK:
  - `handshake_valid_i` with ACK: `tx_ack_o`, flip `tx_toggle[ep]`, go to IDLE.
  - Other handshake, timeout or token: go to IDLE, toggle unchanged, so the host retries the same DATAx.
- Toggles, state and the counter clear on reset or `!enable_i`. Stall has priority over ready; ready has priority over toggle checking.

## Timing
- Reset values:
  - All pulses 0, `tx_valid_o=0`, `tx_pid_o=00`, `ep_o=0`.
  - `rx_toggle_o=0`, `tx_toggle_o=0`, state IDLE.
- All outputs are registered.
- Decisions: the input pulse at edge N produces the state, `tx_valid_o` and pulses at edge N+1.
- TX handshake: `tx_valid_o` and `tx_pid_o` stay stable until the `tx_ready_i` cycle, and deassert on the next edge.
- Timeout counter:
  - Clears on entry to RX_DATA and WAIT_ACK, and increments each cycle.
  - In RX_DATA it freezes after the first `data_valid_i`.
  - The timeout fires when the count equals TIMEOUT; the state is IDLE on the next edge.
- Simultaneous events:
  - `data_complete_i` wins over timeout in the same cycle.
  - ACK wins over timeout in the same cycle.
- `enable_i` low mid-transaction: IDLE next edge, no pulses, `tx_valid_o` drops.

## Test plan
- SETUP ep0, then DATA0 with 8 bytes and good CRC → `tx_pid_o=D2`, `rx_commit_o` and `rx_setup_o` pulse with `ep_o=0`, `rx_toggle_o[0]=1`, `tx_toggle_o[0]=1`.
- OUT ep1 with `rx_ready=0` → NAK 5A plus discard. Retry with ready=1, DATA0 → ACK plus commit, toggle becomes 1. Repeat DATA0 → ACK plus discard.
- IN ep2 ready → `tx_pid_o=C3`; host ACK → `tx_ack_o`. Next IN → 4B with no ACK for 255 cycles → no `tx_ack_o`; next IN → 4B again.
- `ep_stall_i[1]=1`: IN → 1E; OUT plus DATA0 → 1E plus discard; PING → 1E; SETUP plus DATA0 → D2 plus commit.
- OUT ep0 followed by data with `data_crc_err_i=1` → no `tx_valid_o`, `rx_discard_o`. IN ep5 with EP_NUM=4 → no response.
- `enable_i` low in WAIT_ACK and `rst_i` mid TX_HS → IDLE, `tx_valid_o=0`, toggles 0, no pulses.
